// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - divider op encodings, FSM state constants and helpers
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Odd encodings are the unsigned variants.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
module div_step
    import alu_pkg::*;
(
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] div,
    input  logic            dvd_bit,
    output logic [XLEN:0]   rem_next,
    output logic            q_bit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        shifted  = {rem, dvd_bit};
        q_bit    = (shifted >= {2'b00, div});
        diff     = shifted[XLEN:0] - {1'b0, div};
        rem_next = q_bit ? diff : shifted[XLEN:0];
    end

endmodule

// File: rtl/int_div_iter.sv
// rtl/int_div_iter.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), optional INT_DIV_EARLY_OUT_EN
module int_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);
    import alu_pkg::*;

    logic [1:0]      state;
    logic [5:0]      cnt;
    logic [1:0]      op_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] div_q;
    logic            q_neg;
    logic            r_neg;
    logic            b_zero;
    logic            ovf;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            in_b_zero, in_ovf;
    logic [XLEN:0]   step_rem;
    logic            step_q;
    logic [XLEN-1:0] quot_fix, rem_fix;

    always_comb begin
        a_neg     = is_signed_op(i_op) & i_a[XLEN-1];
        b_neg     = is_signed_op(i_op) & i_b[XLEN-1];
        a_abs     = a_neg ? -i_a : i_a;
        b_abs     = b_neg ? -i_b : i_b;
        in_b_zero = (i_b == '0);
        in_ovf    = is_signed_op(i_op) && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
    end

    div_step u_step (
        .rem      (rem_q),
        .div      (div_q),
        .dvd_bit  (dvd_q[XLEN-1]),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Divide-by-zero and signed overflow results are RISC-V defined, not arithmetic.
    always_comb begin
        if (b_zero)
            quot_fix = '1;
        else if (ovf)
            quot_fix = {1'b1, {(XLEN-1){1'b0}}};
        else
            quot_fix = q_neg ? -dvd_q : dvd_q;
        if (ovf)
            rem_fix = '0;
        else
            rem_fix = r_neg ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            div_q    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            b_zero   <= 1'b0;
            ovf      <= 1'b0;
            o_result <= '0;
        end else if (i_flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_q   <= i_op;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        b_zero <= in_b_zero;
                        ovf    <= in_ovf;
                        div_q  <= b_abs;
                        cnt    <= '0;
`ifdef INT_DIV_EARLY_OUT_EN
                        // Trivial cases: quotient 0 and remainder |a|, fixed up in FIX.
                        if (in_b_zero || in_ovf || (a_abs < b_abs)) begin
                            rem_q <= {1'b0, a_abs};
                            dvd_q <= '0;
                            state <= ST_FIX;
                        end else begin
                            rem_q <= '0;
                            dvd_q <= a_abs;
                            state <= ST_CALC;
                        end
`else
                        rem_q <= '0;
                        dvd_q <= a_abs;
                        state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[XLEN-2:0], step_q};
                    cnt   <= cnt + 6'd1;
                    if (cnt == 6'(XLEN - 1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    o_result <= is_rem_op(op_q) ? rem_fix : quot_fix;
                    state    <= ST_DONE;
                end
                default: begin
                    if (i_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_iter.sv
// tb/tb_int_div_iter.sv - self-checking bench for int_div_iter with a reference model
module tb_int_div_iter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_fail   = 0;

    int_div_iter #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension results from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int  sa;
        int  sb;
        bit  of;
        sa = a;
        sb = b;
        of = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : of ? 32'h8000_0000 : 32'(sa / sb);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : of ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef INT_DIV_EARLY_OUT_EN
        longint la;
        longint lb;
        la = op[0] ? longint'(a) : longint'($signed(a));
        lb = op[0] ? longint'(b) : longint'($signed(b));
        if (la < 0) la = -la;
        if (lb < 0) lb = -lb;
        if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || la < lb)
            return 2;
`endif
        return (op == 2'b11 && a == 32'hDEAD_BEEF && b == 32'hDEAD_BEEF) ? 34 : 34;
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns likewise after the handshake.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int bp, input string tag);
        logic [31:0] exp;
        int          lat;
        exp = model(op, a, b);
        check({tag, ":ready"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_op    = 2'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
        lat     = 1;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, ":lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
        check({tag, ":res"}, o_result, exp);
        for (int k = 0; k < bp; k++) begin
            @(posedge i_clk); #1;
            check({tag, ":hold_valid"}, 32'(o_valid), 32'd1);
            check({tag, ":hold_res"}, o_result, exp);
            check({tag, ":hold_ready"}, 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check({tag, ":valid_low"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        int seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_op    = 2'b00;
        i_a     = '0;
        i_b     = '0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_op(2'b01, 32'd100, 32'd7, 0, "divu_100_7");
        run_op(2'b10, -32'sd7, 32'd2, 0, "rem_m7_2");
        run_op(2'b00, -32'sd7, 32'd2, 0, "div_m7_2");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "remu_fff9_2");
        run_op(2'b00, 32'd5, 32'd0, 0, "div_by0");
        run_op(2'b10, 32'd5, 32'd0, 0, "rem_by0");
        run_op(2'b01, 32'd5, 32'd0, 0, "divu_by0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        run_op(2'b00, 32'd3, -32'sd9, 0, "div_small");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5, "divu_bp");
        run_op(2'b10, 32'h7FFF_FFFF, -32'sd3, 0, "rem_b2b");

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(rop, ra, rb, i % 3, "random");
        end

        // Flush on the tenth CALC cycle.
        i_valid = 1'b1; i_op = 2'b01; i_a = 32'd1000; i_b = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        check("flush_ready", 32'(o_ready), 32'd1);
        check("flush_valid", 32'(o_valid), 32'd0);
        // Flush and request together: flush wins, nothing starts.
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_wins_ready", 32'(o_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        run_op(2'b00, 32'd77, 32'd5, 0, "after_flush");

        // Reset held in the middle of CALC.
        i_valid = 1'b1; i_op = 2'b01; i_a = 32'd12345; i_b = 32'd11;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (6) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            check("midrst_ready", 32'(o_ready), 32'd1);
            check("midrst_valid", 32'(o_valid), 32'd0);
            check("midrst_result", o_result, 32'd0);
        end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_op(2'b11, 32'd12345, 32'd11, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
